// File: rtl/fifo_wptr_full.sv
// ---------------------------------------------------------------------------
// fifo_wptr_full
//
// Write-side pointer and full-flag controller for an asynchronous FIFO.
// Lives entirely in the write clock domain. It brings the read side's Gray
// read pointer across with a plain flop chain, keeps the binary write
// pointer, exports the Gray write pointer to the read side, and produces a
// registered full flag, a conservative fill level and an overflow pulse.
//
// Optional feature macro: WPTR_AFULL_EN
//   When defined, adds the registered almost-full output o_wafull, which is
//   high whenever the write-side level is at or above AFULL_THRESH.
//   When undefined, o_wafull and its logic are absent and AFULL_THRESH only
//   takes part in the parameter legality check.
//
// Parameters:
//   ADDR_WIDTH   - FIFO address bits, depth = 2**ADDR_WIDTH (>= 2)
//   SYNC_STAGES  - flops in the read-pointer synchronizer chain (>= 2)
//   AFULL_THRESH - almost-full level, 1 .. 2**ADDR_WIDTH-1
//
// Ports:
//   i_wclk   - write-domain clock (only clock of this block)
//   i_wrst   - asynchronous active-high reset
//   i_winc   - write request for this cycle
//   i_rptr   - Gray read pointer from the read domain (asynchronous)
//   o_waddr  - binary RAM write address for the current write
//   o_wptr   - registered Gray write pointer, sent to the read domain
//   o_wfull  - registered full flag
//   o_wlevel - registered fill level seen from the write side
//   o_wovf   - one-cycle pulse when a write is attempted while full
//   o_wafull - registered almost-full flag (WPTR_AFULL_EN only)
// ---------------------------------------------------------------------------
module fifo_wptr_full #(
    parameter int ADDR_WIDTH   = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  i_wclk,
    input  logic                  i_wrst,
    input  logic                  i_winc,
    input  logic [ADDR_WIDTH:0]   i_rptr,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [ADDR_WIDTH:0]   o_wptr,
    output logic                  o_wfull,
    output logic [ADDR_WIDTH:0]   o_wlevel,
    output logic                  o_wovf
`ifdef WPTR_AFULL_EN
    ,
    output logic                  o_wafull
`endif
);

    // Pointers carry one extra bit beyond the address so that "full" and
    // "empty" can be told apart when the address bits are equal.
    localparam int PW = ADDR_WIDTH + 1;

    // Parameter legality: stop elaboration on settings the pointer and
    // full-compare logic cannot support.
    if (ADDR_WIDTH < 2) begin : g_badAddrWidth
        $error("fifo_wptr_full: ADDR_WIDTH must be 2 or more");
    end
    if (SYNC_STAGES < 2) begin : g_badSyncStages
        $error("fifo_wptr_full: SYNC_STAGES must be 2 or more");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > (2 ** ADDR_WIDTH) - 1)) begin : g_badAfullThresh
        $error("fifo_wptr_full: AFULL_THRESH must be in 1 .. 2**ADDR_WIDTH-1");
    end

    logic [PW-1:0] r_rq [SYNC_STAGES];
    logic [PW-1:0] w_rqSync;
    logic [PW-1:0] w_rbinSync;
    logic [PW-1:0] r_wbin;
    logic [PW-1:0] w_wbinNext;
    logic [PW-1:0] w_wgrayNext;
    logic [PW-1:0] w_fullCmp;
    logic [PW-1:0] w_levelNext;
    logic          w_wrOk;

    // Read-pointer synchronizer. A pure flop chain with nothing between the
    // stages: the Gray encoding guarantees at most one bit changes per read,
    // so any sampled value is either the old or the new pointer.
    always_ff @(posedge i_wclk or posedge i_wrst) begin
        if (i_wrst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_rq[k] <= '0;
            end
        end else begin
            r_rq[0] <= i_rptr;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_rq[k] <= r_rq[k-1];
            end
        end
    end

    assign w_rqSync = r_rq[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at and
    // above it. Written as a reduction of a shifted copy so no bit of the
    // result depends on another bit of the same vector.
    always_comb begin
        w_rbinSync = '0;
        for (int i = 0; i < PW; i++) begin
            w_rbinSync[i] = ^(w_rqSync >> i);
        end
    end

    // Next write pointer. A write is only taken while not full; the binary
    // pointer wraps naturally at 2**PW, which keeps the level arithmetic
    // correct across the wrap.
    assign w_wrOk      = i_winc & ~o_wfull;
    assign w_wbinNext  = r_wbin + {{ADDR_WIDTH{1'b0}}, w_wrOk};
    assign w_wgrayNext = w_wbinNext ^ (w_wbinNext >> 1);

    // The FIFO is full when the next write pointer equals the synchronized
    // read pointer with its top two Gray bits inverted, i.e. exactly one lap
    // ahead. Using the current (stale) read pointer makes full pessimistic:
    // it can linger after a read but never clears early.
    assign w_fullCmp   = {~w_rqSync[PW-1:PW-2], w_rqSync[PW-3:0]};

    // Level uses the same next write pointer and the same synchronized read
    // pointer as the full compare, so full and level == depth always agree.
    assign w_levelNext = w_wbinNext - w_rbinSync;

    // Pointer, flag and level registers. The overflow pulse reflects a
    // request made against the registered full flag; such a write is
    // dropped and leaves no lasting state behind.
    always_ff @(posedge i_wclk or posedge i_wrst) begin
        if (i_wrst) begin
            r_wbin   <= '0;
            o_wptr   <= '0;
            o_wfull  <= 1'b0;
            o_wlevel <= '0;
            o_wovf   <= 1'b0;
        end else begin
            r_wbin   <= w_wbinNext;
            o_wptr   <= w_wgrayNext;
            o_wfull  <= (w_wgrayNext == w_fullCmp);
            o_wlevel <= w_levelNext;
            o_wovf   <= i_winc & o_wfull;
        end
    end

    // The RAM address is the low part of the registered binary pointer; it
    // names the slot the current write (if accepted) lands in.
    assign o_waddr = r_wbin[ADDR_WIDTH-1:0];

`ifdef WPTR_AFULL_EN
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    // Almost-full follows the level with the same timing. Since the
    // threshold is below the depth, it stays high while full as well.
    always_ff @(posedge i_wclk or posedge i_wrst) begin
        if (i_wrst) begin
            o_wafull <= 1'b0;
        end else begin
            o_wafull <= (w_levelNext >= AFULL_LVL);
        end
    end
`endif

endmodule
